// File: rtl/vga_sync_decoder.sv
// Receiving end of a VGA timing stream: rebuilds h/v position from hSync/vSync,
// checks line and frame lengths against nominal totals, and reports lock and active-area coordinates.
module vga_sync_decoder #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_en,
  input  logic       hSync,
  input  logic       vSync,
  output logic [9:0] horiz_pos,
  output logic [9:0] vert_pos,
  output logic       active,
  output logic       locked,
  output logic       frame_start,
  output logic       h_err,
  output logic       v_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  // state   | meaning
  // ACQUIRE | waiting for the first vSync edge after reset
  // TRACK   | counting consecutive clean frames toward lock
  // LOCKED  | timing stable; any line/frame error drops back to TRACK
  typedef enum logic [1:0] {ACQUIRE, TRACK, LOCKED} state_t;

  state_t      state, state_nx;
  logic [3:0]  good, good_nx, good_inc;
  logic        frame_err, frame_err_nx;

  logic        hs_now, vs_now, hs_prev, vs_prev;
  logic        h_edge, v_edge;
  logic [10:0] hcnt, hcnt_nx;
  logic [9:0]  vcnt, vcnt_nx;
  logic        v_hold, v_hold_nx;
  logic        h_seen, v_seen;
  logic        h_err_c, v_err_c, any_err;
  logic        lock_nx, h_win, v_win, act_nx;

  assign hs_now = (hSync == SYNC_POL);
  assign vs_now = (vSync == SYNC_POL);
  assign h_edge = pixel_en & hs_now & ~hs_prev;
  assign v_edge = pixel_en & vs_now & ~vs_prev;

  // Errors use the count as it stands before the edge resets it.
  assign h_err_c  = h_edge & h_seen & (hcnt != H_LAST);
  assign v_err_c  = v_edge & v_seen & (vcnt != V_LAST);
  assign any_err  = h_err_c | v_err_c;
  assign good_inc = good + 4'd1;

  always_comb begin
    hcnt_nx   = hcnt;
    vcnt_nx   = vcnt;
    v_hold_nx = v_hold;
    if (h_edge) begin
      hcnt_nx = '0;
    end else if (pixel_en && (hcnt != '1)) begin
      hcnt_nx = hcnt + 11'd1;
    end
    // A vSync edge off the line boundary must not let the next hSync edge bump vcnt.
    if (v_edge) begin
      vcnt_nx   = '0;
      v_hold_nx = ~h_edge;
    end else if (h_edge) begin
      if (v_hold) begin
        v_hold_nx = 1'b0;
      end else if (vcnt != '1) begin
        vcnt_nx = vcnt + 10'd1;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    good_nx      = good;
    frame_err_nx = frame_err;
    case (state)
      ACQUIRE: begin
        if (v_edge) begin
          state_nx     = TRACK;
          good_nx      = '0;
          frame_err_nx = 1'b0;
        end
      end
      TRACK: begin
        if (v_edge) begin
          frame_err_nx = 1'b0;
          if (!frame_err && !any_err) begin
            good_nx = good_inc;
            if (good_inc == LOCK_N) state_nx = LOCKED;
          end else begin
            good_nx = '0;
          end
        end else if (any_err) begin
          frame_err_nx = 1'b1;
        end
      end
      LOCKED: begin
        // An error on a vSync edge belongs to the frame that just ended.
        if (any_err) begin
          state_nx     = TRACK;
          good_nx      = '0;
          frame_err_nx = ~v_edge;
        end
      end
      default: begin
        state_nx = ACQUIRE;
        good_nx  = '0;
      end
    endcase
  end

  assign lock_nx = (state_nx == LOCKED);
  assign h_win   = (hcnt_nx >= H_START) && (hcnt_nx <= H_END);
  assign v_win   = (vcnt_nx >= V_START) && (vcnt_nx <= V_END);
  assign act_nx  = h_win & v_win & lock_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACQUIRE;
      good      <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      good      <= good_nx;
      frame_err <= frame_err_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      hcnt    <= '0;
      vcnt    <= '0;
      v_hold  <= 1'b0;
      h_seen  <= 1'b0;
      v_seen  <= 1'b0;
    end else begin
      if (pixel_en) begin
        hs_prev <= hs_now;
        vs_prev <= vs_now;
      end
      hcnt   <= hcnt_nx;
      vcnt   <= vcnt_nx;
      v_hold <= v_hold_nx;
      h_seen <= h_seen | h_edge;
      v_seen <= v_seen | v_edge;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      horiz_pos   <= '0;
      vert_pos    <= '0;
      active      <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
    end else begin
      frame_start <= v_edge;
      h_err       <= h_err_c;
      v_err       <= v_err_c;
      locked      <= lock_nx;
      if (pixel_en) begin
        active    <= act_nx;
        horiz_pos <= act_nx ? 10'(hcnt_nx - H_START) : '0;
        vert_pos  <= act_nx ? (vcnt_nx - V_START) : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a reduced-size VGA source drives the decoder frame by frame;
// per-sample expectations go through a scoreboard, per-frame summaries come from a table.
module tb_vga_sync_decoder;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int VT = VA + VF + VS + VB;
  localparam int LOCK = 2;
  localparam int NROWS = 17;

  logic       clk = 1'b0;
  logic       rst, pixel_en, hSync, vSync;
  logic [9:0] horiz_pos, vert_pos;
  logic       active, locked, frame_start, h_err, v_err;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .LOCK_FRAMES(LOCK)
  ) dut (
    .clk(clk), .rst(rst), .pixel_en(pixel_en), .hSync(hSync), .vSync(vSync),
    .horiz_pos(horiz_pos), .vert_pos(vert_pos), .active(active), .locked(locked),
    .frame_start(frame_start), .h_err(h_err), .v_err(v_err)
  );

  typedef struct {
    int hp; int vp; int act; int lk; int fs; int he; int ve;
  } exp_t;

  typedef struct {
    int vt; int bad_line; int stall_v; int rst_v;
    int lk_end; int n_fs; int n_he; int n_ve;
  } row_t;

  exp_t sb[$];
  exp_t last;
  row_t tbl[NROWS];

  int checks = 0, errors = 0;
  int cnt_fs, cnt_he, cnt_ve;

  // Source-side reference state
  bit m_prev_h, m_prev_v, seen_h, seen_v, track, bad;
  int llen, flines, run;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev_h = 0; m_prev_v = 0; seen_h = 0; seen_v = 0;
    track = 0; bad = 0; llen = 0; flines = 0; run = 0;
    last = '{0, 0, 0, 0, 0, 0, 0};
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hpos"}, int'(horiz_pos), 0);
    chk({tag, "_vpos"}, int'(vert_pos), 0);
    chk({tag, "_active"}, int'(active), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_fstart"}, int'(frame_start), 0);
    chk({tag, "_herr"}, int'(h_err), 0);
    chk({tag, "_verr"}, int'(v_err), 0);
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_hpos"}, int'(horiz_pos), last.hp);
    chk({tag, "_vpos"}, int'(vert_pos), last.vp);
    chk({tag, "_active"}, int'(active), last.act);
    chk({tag, "_locked"}, int'(locked), last.lk);
    chk({tag, "_fstart"}, int'(frame_start), 0);
    chk({tag, "_herr"}, int'(h_err), 0);
    chk({tag, "_verr"}, int'(v_err), 0);
  endtask

  task automatic compare_out();
    exp_t e;
    chk("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("hpos", int'(horiz_pos), e.hp);
      chk("vpos", int'(vert_pos), e.vp);
      chk("active", int'(active), e.act);
      chk("locked", int'(locked), e.lk);
      chk("frame_start", int'(frame_start), e.fs);
      chk("h_err", int'(h_err), e.he);
      chk("v_err", int'(v_err), e.ve);
      last = e;
    end
    cnt_fs += int'(frame_start);
    cnt_he += int'(h_err);
    cnt_ve += int'(v_err);
  endtask

  // One source pixel: build the expectation, drive it, check result, then idle a cycle.
  task automatic sample(input int h, input int v);
    exp_t e;
    bit hs_a, vs_a, hedge, vedge, err;
    hs_a  = (h < HS);
    vs_a  = (v < VS);
    hedge = hs_a && !m_prev_h;
    vedge = vs_a && !m_prev_v;
    m_prev_h = hs_a;
    m_prev_v = vs_a;
    e = '{0, 0, 0, 0, 0, 0, 0};
    e.fs = int'(vedge);
    if (hedge) begin
      e.he   = int'(seen_h && (llen != HT));
      seen_h = 1;
      llen   = 1;
    end else begin
      llen++;
    end
    if (vedge) begin
      e.ve   = int'(seen_v && (flines != VT));
      seen_v = 1;
      flines = 1;
    end else if (hedge) begin
      flines++;
    end
    err = (e.he != 0) || (e.ve != 0);
    if (vedge) begin
      if (!track) begin
        track = 1;
        run   = 0;
      end else if (bad || err) begin
        run = 0;
      end else if (run < 15) begin
        run++;
      end
      bad = 0;
    end else if (track && err) begin
      bad = 1;
      run = 0;
    end
    e.lk  = int'(run >= LOCK);
    e.act = int'((e.lk != 0) && h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA);
    e.hp  = (e.act != 0) ? h - (HS + HB) : 0;
    e.vp  = (e.act != 0) ? v - (VS + VB) : 0;
    sb.push_back(e);

    pixel_en = 1'b1;
    hSync    = ~hs_a;
    vSync    = ~vs_a;
    @(negedge clk);
    compare_out();
    pixel_en = 1'b0;
    @(negedge clk);
    chk_hold("idle");
  endtask

  task automatic stall();
    for (int i = 0; i < 1000; i++) begin
      pixel_en = 1'b0;
      hSync    = 1'($urandom);
      vSync    = 1'($urandom);
      @(negedge clk);
      chk_hold("stall");
    end
  endtask

  task automatic mid_reset();
    rst      = 1'b1;
    pixel_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midrst");
    model_reset();
  endtask

  task automatic frame(input row_t r);
    int lt;
    for (int v = 0; v < r.vt; v++) begin
      lt = (v == r.bad_line) ? HT - 1 : HT;
      for (int h = 0; h < lt; h++) begin
        if (v == r.stall_v && h == 12) stall();
        if (v == r.rst_v && h == 10) mid_reset();
        sample(h, v);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          vt    bad stall rst lk fs he ve
    tbl[0]  = '{VT,   -1, -1, -1, 0, 1, 0, 0};
    tbl[1]  = '{VT,   -1, -1, -1, 0, 1, 0, 0};
    tbl[2]  = '{VT,   -1, -1, -1, 1, 1, 0, 0};
    tbl[3]  = '{VT,   -1, -1, -1, 1, 1, 0, 0};
    tbl[4]  = '{VT,    3, -1, -1, 0, 1, 1, 0};
    tbl[5]  = '{VT,   -1, -1, -1, 0, 1, 0, 0};
    tbl[6]  = '{VT,   -1, -1, -1, 0, 1, 0, 0};
    tbl[7]  = '{VT,   -1, -1, -1, 1, 1, 0, 0};
    tbl[8]  = '{VT-1, -1, -1, -1, 1, 1, 0, 0};
    tbl[9]  = '{VT,   -1, -1, -1, 0, 1, 0, 1};
    tbl[10] = '{VT,   -1, -1, -1, 0, 1, 0, 0};
    tbl[11] = '{VT,   -1, -1, -1, 1, 1, 0, 0};
    tbl[12] = '{VT,   -1,  5, -1, 1, 1, 0, 0};
    tbl[13] = '{VT,   -1, -1,  4, 0, 1, 0, 0};
    tbl[14] = '{VT,   -1, -1, -1, 0, 1, 0, 0};
    tbl[15] = '{VT,   -1, -1, -1, 0, 1, 0, 0};
    tbl[16] = '{VT,   -1, -1, -1, 1, 1, 0, 0};

    model_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pixel_en = 1'($urandom);
      hSync    = 1'($urandom);
      vSync    = 1'($urandom);
      @(negedge clk);
      chk_all_zero("reset");
    end
    rst      = 1'b0;
    pixel_en = 1'b0;
    hSync    = 1'b1;
    vSync    = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    for (int i = 0; i < NROWS; i++) begin
      cnt_fs = 0;
      cnt_he = 0;
      cnt_ve = 0;
      frame(tbl[i]);
      chk($sformatf("row%0d_locked", i), int'(locked), tbl[i].lk_end);
      chk($sformatf("row%0d_fstart_count", i), cnt_fs, tbl[i].n_fs);
      chk($sformatf("row%0d_herr_count", i), cnt_he, tbl[i].n_he);
      chk($sformatf("row%0d_verr_count", i), cnt_ve, tbl[i].n_ve);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
